// File: rtl/fifo_xfer_ctl.sv
// FIFO transfer controller: arbitrates fill/drain/flush requests and
// tracks FIFO occupancy with registered one-cycle handshake pulses.
//
// Ports:
//   CLK        in   clock, all state updates on rising edge
//   RST        in   synchronous active-high reset
//   DMAENA     in   enables new fill/drain grants from IDLE
//   FILL_REQ   in   level request to write one longword
//   DRAIN_REQ  in   level request to read one longword
//   FLUSH      in   level request to discard the FIFO contents
//   INCFIFO    out  pulse: a longword is written
//   DECFIFO    out  pulse: a longword is read or discarded
//   FILL_ACK   out  pulse with INCFIFO for a granted fill
//   DRAIN_ACK  out  pulse with DECFIFO for a granted drain
//   FLUSH_DONE out  pulse when a flush completes
//   COUNT      out  current occupancy 0..DEPTH
//   FIFOEMPTY  out  COUNT == 0
//   FIFOFULL   out  COUNT == DEPTH
//   BUSY       out  controller is not in IDLE
module fifo_xfer_ctl #(
    parameter int DEPTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       DMAENA,
    input  logic       FILL_REQ,
    input  logic       DRAIN_REQ,
    input  logic       FLUSH,
    output logic       INCFIFO,
    output logic       DECFIFO,
    output logic       FILL_ACK,
    output logic       DRAIN_ACK,
    output logic       FLUSH_DONE,
    output logic [3:0] COUNT,
    output logic       FIFOEMPTY,
    output logic       FIFOFULL,
    output logic       BUSY
);

    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DRAIN,
        RECOVER,
        FLUSHING
    } state_e;

    state_e     state_q;
    logic [3:0] count_d;
    logic       last_fill_q;
    logic       fill_ok;
    logic       drain_ok;
    logic       grant_fill;
    logic       grant_drain;
    logic       flush_dec;

    // Grant decision for IDLE. When both sides are eligible, the side
    // not served last wins; FLUSH pre-empts everything.
    always_comb begin
        fill_ok     = FILL_REQ && (COUNT < DEPTH_C);
        drain_ok    = DRAIN_REQ && (COUNT != 4'd0);
        grant_fill  = 1'b0;
        grant_drain = 1'b0;
        if (state_q == IDLE && !FLUSH && DMAENA) begin
            if (fill_ok && (!drain_ok || !last_fill_q)) begin
                grant_fill = 1'b1;
            end else if (drain_ok) begin
                grant_drain = 1'b1;
            end
        end
        flush_dec = (state_q == FLUSHING) && (COUNT != 4'd0);
    end

    // Occupancy moves on the same edge that raises the matching pulse,
    // so COUNT and the flags always show the post-update value.
    always_comb begin
        count_d = COUNT;
        if (grant_fill) begin
            count_d = COUNT + 4'd1;
        end else if (grant_drain || flush_dec) begin
            count_d = COUNT - 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            last_fill_q <= 1'b0;
            COUNT       <= 4'd0;
            FIFOEMPTY   <= 1'b1;
            FIFOFULL    <= 1'b0;
            INCFIFO     <= 1'b0;
            DECFIFO     <= 1'b0;
            FILL_ACK    <= 1'b0;
            DRAIN_ACK   <= 1'b0;
            FLUSH_DONE  <= 1'b0;
            BUSY        <= 1'b0;
        end else begin
            COUNT      <= count_d;
            FIFOEMPTY  <= (count_d == 4'd0);
            FIFOFULL   <= (count_d == DEPTH_C);
            INCFIFO    <= 1'b0;
            DECFIFO    <= 1'b0;
            FILL_ACK   <= 1'b0;
            DRAIN_ACK  <= 1'b0;
            FLUSH_DONE <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (FLUSH) begin
                        state_q <= FLUSHING;
                        BUSY    <= 1'b1;
                    end else if (grant_fill) begin
                        state_q     <= FILL;
                        INCFIFO     <= 1'b1;
                        FILL_ACK    <= 1'b1;
                        last_fill_q <= 1'b1;
                        BUSY        <= 1'b1;
                    end else if (grant_drain) begin
                        state_q     <= DRAIN;
                        DECFIFO     <= 1'b1;
                        DRAIN_ACK   <= 1'b1;
                        last_fill_q <= 1'b0;
                        BUSY        <= 1'b1;
                    end else begin
                        BUSY <= 1'b0;
                    end
                end
                FILL, DRAIN: begin
                    state_q <= RECOVER;
                    BUSY    <= 1'b1;
                end
                RECOVER: begin
                    state_q <= IDLE;
                    BUSY    <= 1'b0;
                end
                FLUSHING: begin
                    // One discard per cycle until empty, then report done.
                    if (COUNT != 4'd0) begin
                        DECFIFO <= 1'b1;
                        BUSY    <= 1'b1;
                    end else begin
                        FLUSH_DONE <= 1'b1;
                        state_q    <= IDLE;
                        BUSY       <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_xfer_ctl.sv
// Self-checking bench for fifo_xfer_ctl: per-cycle scoreboard against a
// behavioural model, a vector table, and directed corner sequences.
module tb_fifo_xfer_ctl;

    localparam int DEPTH = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       DMAENA = 1'b0;
    logic       FILL_REQ = 1'b0;
    logic       DRAIN_REQ = 1'b0;
    logic       FLUSH = 1'b0;
    logic       INCFIFO;
    logic       DECFIFO;
    logic       FILL_ACK;
    logic       DRAIN_ACK;
    logic       FLUSH_DONE;
    logic [3:0] COUNT;
    logic       FIFOEMPTY;
    logic       FIFOFULL;
    logic       BUSY;

    fifo_xfer_ctl #(.DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .DMAENA     (DMAENA),
        .FILL_REQ   (FILL_REQ),
        .DRAIN_REQ  (DRAIN_REQ),
        .FLUSH      (FLUSH),
        .INCFIFO    (INCFIFO),
        .DECFIFO    (DECFIFO),
        .FILL_ACK   (FILL_ACK),
        .DRAIN_ACK  (DRAIN_ACK),
        .FLUSH_DONE (FLUSH_DONE),
        .COUNT      (COUNT),
        .FIFOEMPTY  (FIFOEMPTY),
        .FIFOFULL   (FIFOFULL),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       inc;
        logic       dec;
        logic       fa;
        logic       da;
        logic       fd;
        logic       busy;
        logic       empty;
        logic       full;
        logic [3:0] cnt;
    } obs_t;

    typedef struct {
        int rst;
        int ena;
        int fill;
        int drain;
        int flush;
        int n;
        int cnt;
        int empty;
        int full;
        int busy;
    } vec_t;

    localparam int S_IDLE  = 0;
    localparam int S_FILL  = 1;
    localparam int S_DRAIN = 2;
    localparam int S_REC   = 3;
    localparam int S_FLUSH = 4;

    obs_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   m_st = S_IDLE;
    int   m_cnt = 0;
    bit   m_lastf = 1'b0;

    function automatic void check(string name, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Behavioural reference: advances one clock using the driven inputs
    // and returns what the outputs must show after that edge.
    function automatic obs_t model_step();
        obs_t e;
        bit   cf;
        bit   cd;
        e = '0;
        if (RST) begin
            m_st    = S_IDLE;
            m_cnt   = 0;
            m_lastf = 1'b0;
        end else begin
            case (m_st)
                S_IDLE: begin
                    cf = FILL_REQ && (m_cnt < DEPTH);
                    cd = DRAIN_REQ && (m_cnt > 0);
                    if (FLUSH) begin
                        m_st = S_FLUSH;
                    end else if (DMAENA && cf && (!cd || !m_lastf)) begin
                        m_st = S_FILL;
                        m_cnt++;
                        m_lastf = 1'b1;
                        e.inc = 1'b1;
                        e.fa = 1'b1;
                    end else if (DMAENA && cd) begin
                        m_st = S_DRAIN;
                        m_cnt--;
                        m_lastf = 1'b0;
                        e.dec = 1'b1;
                        e.da = 1'b1;
                    end
                end
                S_FILL, S_DRAIN: m_st = S_REC;
                S_REC: m_st = S_IDLE;
                default: begin
                    if (m_cnt > 0) begin
                        m_cnt--;
                        e.dec = 1'b1;
                    end else begin
                        e.fd = 1'b1;
                        m_st = S_IDLE;
                    end
                end
            endcase
        end
        e.cnt   = 4'(m_cnt);
        e.empty = (m_cnt == 0);
        e.full  = (m_cnt == DEPTH);
        e.busy  = (m_st != S_IDLE);
        return e;
    endfunction

    task automatic tick();
        obs_t e;
        obs_t g;
        sb_q.push_back(model_step());
        @(posedge CLK);
        #1;
        e = sb_q.pop_front();
        g = {INCFIFO, DECFIFO, FILL_ACK, DRAIN_ACK, FLUSH_DONE,
             BUSY, FIFOEMPTY, FIFOFULL, COUNT};
        check("cycle", int'(g), int'(e));
    endtask

    task automatic do_reset();
        RST = 1'b1;
        DMAENA = 1'b0;
        FILL_REQ = 1'b0;
        DRAIN_REQ = 1'b0;
        FLUSH = 1'b0;
        tick();
        RST = 1'b0;
    endtask

    task automatic fill_to(input int n);
        DMAENA = 1'b1;
        FILL_REQ = 1'b1;
        for (int k = 0; k < 100 && m_cnt != n; k++) tick();
        FILL_REQ = 1'b0;
        repeat (2) tick();
        check("fill_to", int'(COUNT), n);
    endtask

    task automatic drain_to(input int n);
        DMAENA = 1'b1;
        DRAIN_REQ = 1'b1;
        for (int k = 0; k < 100 && m_cnt != n; k++) tick();
        DRAIN_REQ = 1'b0;
        repeat (2) tick();
        check("drain_to", int'(COUNT), n);
    endtask

    function automatic vec_t mk(int r, int e, int f, int d, int fl,
                                int n, int c, int em, int fu, int bu);
        vec_t v;
        v.rst = r;
        v.ena = e;
        v.fill = f;
        v.drain = d;
        v.flush = fl;
        v.n = n;
        v.cnt = c;
        v.empty = em;
        v.full = fu;
        v.busy = bu;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[14];
        int   npulse;
        int   last_i;
        int   ndec;
        int   ninc;
        int   ngrant;
        int   first_dec;
        int   last_dec;
        int   done_at;
        int   ndone;

        //         rst ena fil drn fls  n cnt emp ful bsy
        vt[0]  = mk(1, 0, 0, 0, 0, 2, 0, 1, 0, 0);
        vt[1]  = mk(0, 1, 1, 0, 0, 3, 1, 0, 0, 0);
        vt[2]  = mk(0, 1, 1, 0, 0, 1, 2, 0, 0, 1);
        vt[3]  = mk(0, 1, 0, 0, 0, 2, 2, 0, 0, 0);
        vt[4]  = mk(0, 1, 0, 1, 0, 1, 1, 0, 0, 1);
        vt[5]  = mk(0, 1, 0, 0, 0, 2, 1, 0, 0, 0);
        vt[6]  = mk(0, 1, 0, 0, 1, 1, 1, 0, 0, 1);
        vt[7]  = mk(0, 1, 0, 0, 0, 1, 0, 1, 0, 1);
        vt[8]  = mk(0, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        vt[9]  = mk(0, 0, 1, 0, 0, 3, 0, 1, 0, 0);
        vt[10] = mk(0, 1, 1, 1, 0, 1, 1, 0, 0, 1);
        vt[11] = mk(0, 1, 1, 1, 0, 2, 1, 0, 0, 0);
        vt[12] = mk(0, 1, 1, 1, 0, 1, 0, 1, 0, 1);
        vt[13] = mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);

        for (int i = 0; i < 14; i++) begin
            RST = vt[i].rst[0];
            DMAENA = vt[i].ena[0];
            FILL_REQ = vt[i].fill[0];
            DRAIN_REQ = vt[i].drain[0];
            FLUSH = vt[i].flush[0];
            repeat (vt[i].n) tick();
            check($sformatf("vec%0d_count", i), int'(COUNT), vt[i].cnt);
            check($sformatf("vec%0d_empty", i), int'(FIFOEMPTY), vt[i].empty);
            check($sformatf("vec%0d_full", i), int'(FIFOFULL), vt[i].full);
            check($sformatf("vec%0d_busy", i), int'(BUSY), vt[i].busy);
        end

        // Fill held for 30 cycles: one write every 3rd cycle until full.
        do_reset();
        DMAENA = 1'b1;
        FILL_REQ = 1'b1;
        npulse = 0;
        last_i = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (INCFIFO) begin
                if (npulse > 0) check("fill_gap", i - last_i, 3);
                npulse++;
                last_i = i;
            end
        end
        FILL_REQ = 1'b0;
        check("fill_pulses", npulse, DEPTH);
        check("fill_count", int'(COUNT), DEPTH);
        check("fill_full", int'(FIFOFULL), 1);

        // Both requests at COUNT=4 with drain served last: fill, drain, ...
        do_reset();
        fill_to(5);
        drain_to(4);
        FILL_REQ = 1'b1;
        DRAIN_REQ = 1'b1;
        ngrant = 0;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (INCFIFO || DECFIFO) begin
                check("alt_kind", int'(INCFIFO), (ngrant % 2 == 0) ? 1 : 0);
                check("alt_count", int'(COUNT), (ngrant % 2 == 0) ? 5 : 4);
                ngrant++;
            end
        end
        FILL_REQ = 1'b0;
        DRAIN_REQ = 1'b0;
        check("alt_grants", ngrant, 6);
        repeat (2) tick();

        // Drain on an empty FIFO is never granted.
        do_reset();
        DMAENA = 1'b1;
        DRAIN_REQ = 1'b1;
        ndec = 0;
        repeat (10) begin
            tick();
            if (DECFIFO) ndec++;
        end
        DRAIN_REQ = 1'b0;
        check("empty_drain_dec", ndec, 0);
        check("empty_drain_empty", int'(FIFOEMPTY), 1);
        check("empty_drain_busy", int'(BUSY), 0);

        // Flush of 6 entries: 6 back-to-back discards, then done.
        do_reset();
        fill_to(6);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        ndec = 0;
        first_dec = -1;
        last_dec = -1;
        done_at = -1;
        for (int k = 0; k < 20 && done_at < 0; k++) begin
            tick();
            if (DECFIFO) begin
                if (first_dec < 0) first_dec = k;
                last_dec = k;
                ndec++;
            end
            if (FLUSH_DONE) done_at = k;
        end
        check("flush_dec", ndec, 6);
        check("flush_span", last_dec - first_dec, 5);
        check("flush_done_at", done_at, last_dec + 1);
        check("flush_count", int'(COUNT), 0);
        check("flush_busy", int'(BUSY), 0);
        tick();

        // DMAENA low blocks grants but not FLUSH.
        do_reset();
        fill_to(2);
        DMAENA = 1'b0;
        FILL_REQ = 1'b1;
        DRAIN_REQ = 1'b1;
        ninc = 0;
        ndec = 0;
        repeat (10) begin
            tick();
            if (INCFIFO) ninc++;
            if (DECFIFO) ndec++;
        end
        check("noena_inc", ninc, 0);
        check("noena_dec", ndec, 0);
        check("noena_count", int'(COUNT), 2);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        ndone = 0;
        for (int k = 0; k < 10 && ndone == 0; k++) begin
            tick();
            if (FLUSH_DONE) ndone++;
        end
        check("noena_flush_done", ndone, 1);
        check("noena_flush_count", int'(COUNT), 0);
        FILL_REQ = 1'b0;
        DRAIN_REQ = 1'b0;

        // Reset in the middle of a flush kills it cleanly.
        do_reset();
        fill_to(5);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        for (int k = 0; k < 10 && m_cnt != 3; k++) tick();
        check("rstflush_at3", int'(COUNT), 3);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rstflush_count", int'(COUNT), 0);
        check("rstflush_empty", int'(FIFOEMPTY), 1);
        check("rstflush_dec", int'(DECFIFO), 0);
        ndone = 0;
        ndec = 0;
        repeat (6) begin
            tick();
            if (FLUSH_DONE) ndone++;
            if (DECFIFO) ndec++;
        end
        check("rstflush_nodone", ndone, 0);
        check("rstflush_nodec", ndec, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
